mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM port between instruction fetch (IF) and the
//  MEM stage. Sequences 1/2/4-byte accesses as consecutive byte cycles and

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the MEM stage. 1/2/4-byte accesses run as consecutive byte cycles and
// are assembled/split little-endian. MEM has fixed priority over IF, and an
// access in flight is never preempted.
// Optional feature: define MEM_ARBITER_IF_FLUSH_EN to add the if_clr input,
// which cancels an IF-owned read (no if_ok is delivered).
module mem_arbiter #(
    parameter int RD_LAT = 1            // RAM read latency, 1..2 cycles
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_a,
    output logic [31:0] if_n,
    output logic        if_ok,
`ifdef MEM_ARBITER_IF_FLUSH_EN
    input  logic        if_clr,
`endif
    input  logic        mm_req,
    input  logic        mm_wr,
    input  logic [1:0]  mm_len,
    input  logic [31:0] mm_a,
    input  logic [31:0] mm_n_i,
    output logic [31:0] mm_n_o,
    output logic        mm_ok,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        ram_wr,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic        own_mm_q;      // 1: MEM owns the current access, 0: IF
    logic [2:0]  n_q;           // access length in bytes (1, 2 or 4)
    logic [2:0]  cyc_q;         // cycles spent in RD/WR so far
    logic [31:0] wdata_q;       // latched write word
    logic [31:0] buf_q;         // read bytes captured so far
    logic [31:0] ram_a_q;
    logic [7:0]  ram_dout_q;
    logic        ram_wr_q;
    logic [31:0] if_n_q;
    logic [31:0] mm_n_q;
    logic        if_ok_q;
    logic        mm_ok_q;
    logic        busy_q;

    logic        more_issue;    // another byte address follows this cycle's
    logic        cap_en;        // ram_din carries a byte of this access now
    logic        last_cap;      // ram_din carries the final byte now
    logic [1:0]  cap_lane;
    logic [31:0] rd_word_d;     // buf_q with this cycle's byte merged in
    logic        flush;

    // Pick byte i out of a little-endian word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // Replace byte lane i of a word.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{i, 3'b000} +: 8] = b;
        return r;
    endfunction

    // Map the MEM length code to a byte count.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

`ifdef MEM_ARBITER_IF_FLUSH_EN
    assign flush = if_clr && !own_mm_q;
`else
    assign flush = 1'b0;
`endif

    // Byte sequencing: address i is issued at cyc=i, its data returns RD_LAT later.
    always_comb begin
        more_issue = (cyc_q + 3'd1) < n_q;
        cap_en     = cyc_q >= 3'(RD_LAT);
        cap_lane   = 2'(cyc_q - 3'(RD_LAT));
        last_cap   = cap_en && (cyc_q == (n_q + 3'(RD_LAT) - 3'd1));
        rd_word_d  = cap_en ? put_byte(buf_q, cap_lane, ram_din) : buf_q;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            own_mm_q   <= 1'b0;
            n_q        <= 3'd0;
            cyc_q      <= 3'd0;
            ram_a_q    <= 32'h0;
            ram_dout_q <= 8'h0;
            ram_wr_q   <= 1'b0;
            if_n_q     <= 32'h0;
            mm_n_q     <= 32'h0;
            if_ok_q    <= 1'b0;
            mm_ok_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cyc_q <= 3'd0;
                    buf_q <= 32'h0;
                    if (mm_req) begin
                        own_mm_q   <= 1'b1;
                        n_q        <= len_bytes(mm_len);
                        wdata_q    <= mm_n_i;
                        ram_a_q    <= mm_a;
                        ram_dout_q <= mm_n_i[7:0];
                        ram_wr_q   <= mm_wr;
                        busy_q     <= 1'b1;
                        state_q    <= mm_wr ? S_WR : S_RD;
                    end else if (if_req) begin
                        own_mm_q   <= 1'b0;
                        n_q        <= 3'd4;
                        ram_a_q    <= if_a;
                        ram_wr_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cyc_q <= cyc_q + 3'd1;
                        buf_q <= rd_word_d;
                        if (more_issue) begin
                            ram_a_q <= ram_a_q + 32'd1;
                        end
                        if (last_cap) begin
                            state_q <= S_DONE;
                            if (own_mm_q) begin
                                mm_n_q  <= rd_word_d;
                                mm_ok_q <= 1'b1;
                            end else begin
                                if_n_q  <= rd_word_d;
                                if_ok_q <= 1'b1;
                            end
                        end
                    end
                end
                S_WR: begin
                    cyc_q <= cyc_q + 3'd1;
                    if (more_issue) begin
                        ram_a_q    <= ram_a_q + 32'd1;
                        ram_dout_q <= byte_of(wdata_q, cyc_q[1:0] + 2'd1);
                    end else begin
                        ram_wr_q <= 1'b0;
                        mm_ok_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    // DONE: ok was visible for one cycle; requests are sampled next cycle.
                    if_ok_q <= 1'b0;
                    mm_ok_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_n     = if_n_q;
    assign mm_n_o   = mm_n_q;
    assign mm_ok    = mm_ok_q;
    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q;
    assign busy     = busy_q;
`ifdef MEM_ARBITER_IF_FLUSH_EN
    // A flush arriving in the DONE cycle still suppresses the IF completion.
    assign if_ok    = if_ok_q & ~if_clr;
`else
    assign if_ok    = if_ok_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (RD_LAT=1) and a
// scoreboard of expected completions (owner, cycle, data).
module tb_mem_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_a;
    logic [31:0] if_n;
    logic        if_ok;
`ifdef MEM_ARBITER_IF_FLUSH_EN
    logic        if_clr;
`endif
    logic        mm_req;
    logic        mm_wr;
    logic [1:0]  mm_len;
    logic [31:0] mm_a;
    logic [31:0] mm_n_i;
    logic [31:0] mm_n_o;
    logic        mm_ok;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic        busy;

    logic        pre_we;
    logic [31:0] pre_a;
    logic [7:0]  pre_d;
    logic [7:0]  mem [logic [31:0]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string       tag;
        bit          is_mm;
        bit          chk_data;
        logic [31:0] data;
        int          ok_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: one-cycle read latency, writes on the strobe.
    always @(posedge clk) begin
        ram_din <= mem.exists(ram_a) ? mem[ram_a] : 8'h00;
        if (pre_we) mem[pre_a] = pre_d;
        else if (ram_wr) mem[ram_a] = ram_dout;
    end

    mem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_a(if_a), .if_n(if_n), .if_ok(if_ok),
`ifdef MEM_ARBITER_IF_FLUSH_EN
        .if_clr(if_clr),
`endif
        .mm_req(mm_req), .mm_wr(mm_wr), .mm_len(mm_len), .mm_a(mm_a),
        .mm_n_i(mm_n_i), .mm_n_o(mm_n_o), .mm_ok(mm_ok),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    task automatic mm_start(input string tag, input bit wr, input logic [1:0] len,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] want);
        exp_t e;
        int   n;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        mm_req = 1'b1; mm_wr = wr; mm_len = len; mm_a = a; mm_n_i = d;
        e.tag = tag; e.is_mm = 1'b1; e.chk_data = !wr; e.data = want;
        e.ok_cyc = wr ? (cyc + 1 + n) : (cyc + 1 + n + RD_LAT);
        sb.push_back(e);
    endtask

    // delay: cycles the IF grant is held back behind another access.
    task automatic if_start(input string tag, input logic [31:0] a,
                            input logic [31:0] want, input int delay);
        exp_t e;
        if_req = 1'b1; if_a = a;
        e.tag = tag; e.is_mm = 1'b0; e.chk_data = 1'b1; e.data = want;
        e.ok_cyc = cyc + delay + 1 + 4 + RD_LAT;
        sb.push_back(e);
    endtask

    task automatic wait_ok();
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while (!(mm_ok || if_ok) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        if (!(mm_ok || if_ok)) begin
            chk({e.tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({e.tag, "_owner"}, {31'd0, mm_ok}, {31'd0, e.is_mm});
        chk({e.tag, "_single_ok"}, {31'd0, mm_ok & if_ok}, 32'd0);
        chk({e.tag, "_cycle"}, cyc, e.ok_cyc);
        if (e.chk_data) chk({e.tag, "_data"}, e.is_mm ? mm_n_o : if_n, e.data);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_a = '0; mm_req = 1'b0; mm_wr = 1'b0;
        mm_len = '0; mm_a = '0; mm_n_i = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
`ifdef MEM_ARBITER_IF_FLUSH_EN
        if_clr = 1'b0;
`endif
        step();
        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33);
        poke(32'h103, 8'h44); poke(32'h104, 8'h55); poke(32'h021, 8'h77);
        poke(32'h004, 8'h5A); poke(32'h005, 8'hA5);
        poke(32'h200, 8'h01); poke(32'h201, 8'h02); poke(32'h202, 8'h03);
        poke(32'h203, 8'h04);
        poke(32'hFFFF_FFFE, 8'hA1); poke(32'hFFFF_FFFF, 8'hB2);
        poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mm_ok", {31'd0, mm_ok}, 32'd0);
        chk("rst_if_ok", {31'd0, if_ok}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        chk("rst_ram_a", ram_a, 32'h0);
        chk("rst_mm_n_o", mm_n_o, 32'h0);
        chk("rst_if_n", if_n, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Word read, little-endian assembly.
        mm_start("wrd_rd", 1'b0, 2'b10, 32'h100, 32'h0, 32'h4433_2211);
        wait_ok();
        step();

        // Byte write: a single strobe cycle.
        mm_start("bwr", 1'b1, 2'b00, 32'h20, 32'hAABB_CCDD, 32'h0);
        step();
        @(negedge clk);
        chk("bwr_ram_wr", {31'd0, ram_wr}, 32'd1);
        chk("bwr_ram_a", ram_a, 32'h20);
        chk("bwr_ram_dout", {24'd0, ram_dout}, 32'hDD);
        wait_ok();
        chk("bwr_one_strobe", {31'd0, ram_wr}, 32'd0);
        step();
        mm_start("bwr_rb", 1'b0, 2'b00, 32'h20, 32'h0, 32'h0000_00DD);
        wait_ok();
        step();

        // Half write then word readback: upper bytes untouched.
        mm_start("hwr", 1'b1, 2'b01, 32'h40, 32'h1234_BEEF, 32'h0);
        wait_ok();
        step();
        mm_start("hwr_rb", 1'b0, 2'b10, 32'h40, 32'h0, 32'h0000_BEEF);
        wait_ok();
        step();

        // Unaligned word read.
        mm_start("unal_rd", 1'b0, 2'b10, 32'h101, 32'h0, 32'h5544_3322);
        wait_ok();
        step();
        mm_req = 1'b0;
        step();

        // Contention: MEM first, IF granted in the idle cycle after mm_ok.
        mm_start("cont_mm", 1'b0, 2'b01, 32'h4, 32'h0, 32'h0000_A55A);
        if_start("cont_if", 32'h200, 32'h0403_0201, 1 + 2 + RD_LAT + 1);
        wait_ok();
        step();
        mm_req = 1'b0;
        @(negedge clk);
        chk("cont_idle_gap", {31'd0, busy}, 32'd0);
        wait_ok();
        step();
        if_req = 1'b0;
        step();

        // Address wrap on an IF fetch.
        if_start("wrap_if", 32'hFFFF_FFFE, 32'hD4C3_B2A1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("wrap_ram_a%0d", i), ram_a, 32'hFFFF_FFFE + 32'(i));
        end
        wait_ok();
        step();
        if_req = 1'b0;
        step();

        // Reset in the middle of a word write.
        mm_req = 1'b1; mm_wr = 1'b1; mm_len = 2'b10; mm_a = 32'h80; mm_n_i = 32'hCAFE_F00D;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_ram_wr_c2", {31'd0, ram_wr}, 32'd1);
        chk("rstw_ram_a_c2", ram_a, 32'h81);
        step();
        rst = 1'b0; mm_req = 1'b0;
        @(negedge clk);
        chk("rstw_ram_wr_c3", {31'd0, ram_wr}, 32'd0);
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_ram_a", ram_a, 32'h0);
        chk("rstw_mm_n_o", mm_n_o, 32'h0);
        chk("rstw_if_n", if_n, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("rstw_no_ok%0d", i), {30'd0, mm_ok, ram_wr}, 32'd0);
        end
        step();
        mm_start("rstw_rb", 1'b0, 2'b10, 32'h80, 32'h0, 32'h0000_F00D);
        wait_ok();
        step();
        mm_req = 1'b0;
        step();

`ifdef MEM_ARBITER_IF_FLUSH_EN
        // Flush an IF read; a pending MEM request takes over right after.
        if_req = 1'b1; if_a = 32'h200;
        step();
        mm_start("flush_mm", 1'b0, 2'b00, 32'h100, 32'h0, 32'h0000_0011);
        sb[0].ok_cyc = cyc + 3 + 1 + 1 + RD_LAT;
        step();
        step();
        if_clr = 1'b1;
        step();
        if_clr = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_no_ok", {31'd0, if_ok}, 32'd0);
        wait_ok();
        step();
        mm_req = 1'b0;
        step();
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
